alu16_sequencer: RTL

Sequencing controller for the team's 16-bit ALU datapath. It accepts one operation at a time through a valid/ready handshake and drives an internal combinational ALU core. Single-cycle operations complete after one execute cycle. Multiply runs as a multi-cycle shift-add. The block registers the result and flags and holds them until the consumer accepts them. It sits between the instruction/test front end and the result sink, and it is the only owner of the ALU core.

---
 rtl/alu16_pkg.sv | 23 ++
 rtl/alu16_sequencer_if.sv | 29 ++
 rtl/alu16_core.sv | 56 +++++
 rtl/alu16_gates.sv | 17 +
 rtl/alu16_sequencer.sv | 139 +++++++++++++
 5 files changed

// File: rtl/alu16_pkg.sv
// rtl/alu16_pkg.sv - shared opcodes, FSM state encoding and widths for the ALU16 sequencer
package alu16_pkg;

    localparam int WIDTH = 16;
    localparam int OPW   = 4;

    localparam logic [OPW-1:0] OP_ADD = 4'd0;
    localparam logic [OPW-1:0] OP_SUB = 4'd1;
    localparam logic [OPW-1:0] OP_AND = 4'd2;
    localparam logic [OPW-1:0] OP_OR  = 4'd3;
    localparam logic [OPW-1:0] OP_XOR = 4'd4;
    localparam logic [OPW-1:0] OP_NOT = 4'd5;
    localparam logic [OPW-1:0] OP_SHL = 4'd6;
    localparam logic [OPW-1:0] OP_SHR = 4'd7;
    localparam logic [OPW-1:0] OP_MUL = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu16_sequencer_if.sv
// rtl/alu16_sequencer_if.sv - request/response bus between front end, sequencer and result sink
//   master: drives in_valid/op/a/b/out_ready, receives in_ready/out_valid/result/carry/zero/err
//   slave : the sequencer side of the same signals
interface alu16_sequencer_if #(
    parameter int W  = alu16_pkg::WIDTH,
    parameter int OW = alu16_pkg::OPW
) ();
    logic          in_valid;
    logic          in_ready;
    logic [OW-1:0] op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [2*W-1:0] result;
    logic          carry;
    logic          zero;
    logic          err;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, carry, zero, err
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, carry, zero, err
    );
endinterface

// File: rtl/alu16_core.sv
// rtl/alu16_core.sv - combinational ALU core (ADD/SUB/AND/OR/XOR/NOT/SHL/SHR), flags illegal ops
//   op in OPW ; a, b in W ; y out W ; carry out 1 ; illegal out 1
//   ALU16_SEQ_MUL_EN: when undefined, opcode MUL is reported illegal here
module alu16_core
    import alu16_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic [OPW-1:0] op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [W-1:0]   y,
    output logic           carry,
    output logic           illegal
);
`ifdef ALU16_SEQ_MUL_EN
    localparam bit MUL_ILLEGAL = 1'b0;
`else
    localparam bit MUL_ILLEGAL = 1'b1;
`endif

    logic [W-1:0] g_and, g_or, g_xor, g_not;
    logic [W:0]   sum, diff;

    alu16_bitwise_gates #(.W(W)) u_gates (
        .a     (a),
        .b     (b),
        .y_and (g_and),
        .y_or  (g_or),
        .y_xor (g_xor),
        .y_not (g_not)
    );

    assign sum  = {1'b0, a} + {1'b0, b};
    // Two's-complement subtract: the carry-out is the no-borrow flag (a >= b).
    assign diff = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);

    always_comb begin
        y       = '0;
        carry   = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_ADD:  {carry, y} = sum;
            OP_SUB:  {carry, y} = diff;
            OP_AND:  y = g_and;
            OP_OR:   y = g_or;
            OP_XOR:  y = g_xor;
            OP_NOT:  y = g_not;
            OP_SHL:  y = a << b[3:0];
            OP_SHR:  y = a >> b[3:0];
            // MUL is executed by the sequencer's shift-add datapath, never by this core.
            OP_MUL:  illegal = MUL_ILLEGAL;
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/alu16_gates.sv
// rtl/alu16_gates.sv - bitwise gate helper: AND/OR/XOR of a,b and NOT of a
//   a, b in W ; y_and, y_or, y_xor, y_not out W
module alu16_bitwise_gates #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y_and,
    output logic [W-1:0] y_or,
    output logic [W-1:0] y_xor,
    output logic [W-1:0] y_not
);
    assign y_and = a & b;
    assign y_or  = a | b;
    assign y_xor = a ^ b;
    assign y_not = ~a;
endmodule

// File: rtl/alu16_sequencer.sv
// rtl/alu16_sequencer.sv - one-at-a-time ALU sequencer: IDLE/EXEC/DONE FSM, result hold, shift-add MUL
//   clk, rst_n (async active-low) ; bus: alu16_sequencer_if.slave ; busy out 1
//   ALU16_SEQ_MUL_EN: builds the 16-iteration shift-add multiplier; otherwise MUL is illegal
module alu16_sequencer
    import alu16_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    alu16_sequencer_if.slave   bus,
    output logic               busy
);
    localparam int W2 = 2 * WIDTH;

    state_e           state_q, state_d;
    logic [OPW-1:0]   op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [W2-1:0]    res_q, res_d;
    logic             carry_q, carry_d, zero_q, zero_d, err_q, err_d;

    logic [WIDTH-1:0] core_y;
    logic             core_carry, core_illegal;

`ifdef ALU16_SEQ_MUL_EN
    logic [W2-1:0] mcand_q, mcand_d, acc_q, acc_d, acc_sum;
    logic [4:0]    cnt_q, cnt_d;
`endif

    alu16_core #(.W(WIDTH)) u_core (
        .op      (op_q),
        .a       (a_q),
        .b       (b_q),
        .y       (core_y),
        .carry   (core_carry),
        .illegal (core_illegal)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        err_d   = err_q;
`ifdef ALU16_SEQ_MUL_EN
        mcand_d = mcand_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        acc_sum = acc_q + (b_q[0] ? mcand_q : '0);
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    op_d    = bus.op;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    state_d = EXEC;
`ifdef ALU16_SEQ_MUL_EN
                    mcand_d = {{WIDTH{1'b0}}, bus.a};
                    acc_d   = '0;
                    cnt_d   = '0;
`endif
                end
            end
            EXEC: begin
`ifdef ALU16_SEQ_MUL_EN
                if (op_q == OP_MUL) begin
                    // b_q is consumed LSB-first; each step adds the shifted multiplicand.
                    acc_d   = acc_sum;
                    mcand_d = mcand_q << 1;
                    b_d     = b_q >> 1;
                    cnt_d   = cnt_q + 5'd1;
                    if (cnt_q == 5'(WIDTH - 1)) begin
                        res_d   = acc_sum;
                        carry_d = 1'b0;
                        zero_d  = (acc_sum == '0);
                        err_d   = 1'b0;
                        state_d = DONE;
                    end
                end else
`endif
                begin
                    res_d   = {{WIDTH{1'b0}}, core_y};
                    carry_d = core_carry;
                    zero_d  = (core_y == '0);
                    err_d   = core_illegal;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef ALU16_SEQ_MUL_EN
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
`ifdef ALU16_SEQ_MUL_EN
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = res_q;
    assign bus.carry     = carry_q;
    assign bus.zero      = zero_q;
    assign bus.err       = err_q;
    assign busy          = (state_q != IDLE);
endmodule
